// File: rtl/showdown_pkg.sv
// Shared widths, hand-category encodings and FSM state type for the showdown judge.
package showdown_pkg;
    localparam int LEVEL_W = 3;
    localparam int RANK_W  = 4;

    typedef enum logic [LEVEL_W-1:0] {
        HIGH_CARD  = 3'd0,
        ONE_PAIR   = 3'd1,
        TWO_PAIR   = 3'd2,
        THREE_KIND = 3'd3,
        STRAIGHT   = 3'd4,
        FLUSH      = 3'd5,
        FULL_HOUSE = 3'd6,
        FOUR_KIND  = 3'd7
    } level_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_REPORT
    } state_e;
endpackage

// File: rtl/hand_compare.sv
// Combinational hand comparator; {level, kickers} packed MSB-first so a plain
// unsigned compare is the lexicographic hand order.
module hand_compare #(
    parameter int W = 19
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);
    assign gt = (a > b);
    assign eq = (a == b);
endmodule

// File: rtl/showdown_judge.sv
// Streams one hand record per seat, tracks the best hand and the set of seats
// tied on it, and reports the winners one cycle after the last seat arrives.
module showdown_judge
    import showdown_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int NUM_KICKERS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_fold,
    input  logic [LEVEL_W-1:0]            in_level,
    input  logic [RANK_W*NUM_KICKERS-1:0] in_kickers,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PLAYERS-1:0]        winner_mask,
    output logic [LEVEL_W-1:0]            best_level,
    output logic                          split,
    output logic                          no_winner
);
    localparam int HAND_W = LEVEL_W + RANK_W * NUM_KICKERS;
    localparam int SEAT_W = $clog2(NUM_PLAYERS);

    state_e                 state_q, state_d;
    logic [SEAT_W-1:0]      seat_q, seat_d;
    logic                   best_vld_q, best_vld_d;
    logic [HAND_W-1:0]      best_q, best_d;
    logic [NUM_PLAYERS-1:0] mask_q, mask_d;
    logic [NUM_PLAYERS-1:0] win_mask_q, win_mask_d;
    logic [LEVEL_W-1:0]     best_level_q, best_level_d;
    logic                   split_q, split_d;
    logic                   no_winner_q, no_winner_d;

    logic [HAND_W-1:0]      new_hand;
    logic [NUM_PLAYERS-1:0] seat_oh;
    logic                   cmp_gt, cmp_eq, accept, last_seat;

    assign new_hand  = {in_level, in_kickers};
    assign seat_oh   = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << seat_q;
    assign in_ready  = (state_q == S_COLLECT);
    assign accept    = in_valid & in_ready;
    assign last_seat = (seat_q == SEAT_W'(NUM_PLAYERS - 1));

    hand_compare #(.W(HAND_W)) u_cmp (
        .a  (new_hand),
        .b  (best_q),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    always_comb begin
        state_d      = state_q;
        seat_d       = seat_q;
        best_vld_d   = best_vld_q;
        best_d       = best_q;
        mask_d       = mask_q;
        win_mask_d   = win_mask_q;
        best_level_d = best_level_q;
        split_d      = split_q;
        no_winner_d  = no_winner_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_COLLECT;
                    seat_d       = '0;
                    best_vld_d   = 1'b0;
                    best_d       = '0;
                    mask_d       = '0;
                    win_mask_d   = '0;
                    best_level_d = '0;
                    split_d      = 1'b0;
                    no_winner_d  = 1'b0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    seat_d = seat_q + SEAT_W'(1);
                    if (!in_fold) begin
                        // First live hand always takes the lead regardless of compare.
                        if (!best_vld_q || cmp_gt) begin
                            best_d     = new_hand;
                            mask_d     = seat_oh;
                            best_vld_d = 1'b1;
                        end else if (cmp_eq) begin
                            mask_d = mask_q | seat_oh;
                        end
                    end
                    if (last_seat) begin
                        state_d      = S_REPORT;
                        win_mask_d   = mask_d;
                        best_level_d = best_vld_d ? best_d[HAND_W-1 -: LEVEL_W] : '0;
                        split_d      = |(mask_d & (mask_d - NUM_PLAYERS'(1)));
                        no_winner_d  = !best_vld_d;
                    end
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            seat_q       <= '0;
            best_vld_q   <= 1'b0;
            best_q       <= '0;
            mask_q       <= '0;
            win_mask_q   <= '0;
            best_level_q <= '0;
            split_q      <= 1'b0;
            no_winner_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            seat_q       <= seat_d;
            best_vld_q   <= best_vld_d;
            best_q       <= best_d;
            mask_q       <= mask_d;
            win_mask_q   <= win_mask_d;
            best_level_q <= best_level_d;
            split_q      <= split_d;
            no_winner_q  <= no_winner_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_REPORT);
    assign winner_mask = win_mask_q;
    assign best_level  = best_level_q;
    assign split       = split_q;
    assign no_winner   = no_winner_q;
endmodule
